fetch_queue: RTL

- Instruction prefetch FIFO directly downstream of the program counter / instruction memory in the IF stage.
- Buffers (PC, instruction) pairs so fetch keeps running while ID stalls.
- Supplies the PC write-enable back to the program counter.
- Empties in one cycle on a branch or jump flush.

---
 rtl/fetch_queue.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction prefetch FIFO in the IF stage. It sits directly downstream of
// the program counter / instruction memory and buffers (PC, instruction)
// pairs so that fetch keeps running while ID stalls. It drives PCWrite back
// to the program counter and empties in one cycle on a branch/jump flush.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN
//   When defined, an empty queue forwards pc_in/instr_in straight to the
//   outputs in the same cycle. If ID takes the entry, it is never stored.
//   When undefined, there is no combinational input-to-output path and the
//   minimum fetch-to-ID latency is one cycle.
//
// Parameters:
//   DEPTH  number of entries (power of 2, >= 2)
//   AW     pointer width, log2(DEPTH)
//
// Ports:
//   clk          system clock, rising-edge
//   reset        asynchronous active-high reset
//   pc_in        PC of the fetched instruction
//   instr_in     instruction word read at pc_in
//   fetch_valid  pc_in/instr_in valid this cycle
//   id_ready     ID accepts the head entry this cycle
//   flush        discard all entries (branch/jump taken)
//   pc_write     PCWrite to the program counter (= ~full)
//   pc_out       PC of the head entry (0 when nothing valid)
//   instr_out    instruction of the head entry (0 when nothing valid)
//   out_valid    head entry valid
//   full         count == DEPTH
//   empty        count == 0
//   count        occupied entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   pc_in,
    input  logic [15:0]   instr_in,
    input  logic          fetch_valid,
    input  logic          id_ready,
    input  logic          flush,
    output logic          pc_write,
    output logic [15:0]   pc_out,
    output logic [15:0]   instr_out,
    output logic          out_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    // Storage; contents are don't-care after reset, so no reset is applied.
    logic [15:0] mem_pc_q    [DEPTH];
    logic [15:0] mem_instr_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;

    assign full_s  = (count_q == DEPTH_CNT);
    assign empty_s = (count_q == {(AW + 1){1'b0}});

`ifdef FETCH_QUEUE_BYPASS_EN
    logic          bypass_s;
    logic          bypass_take_s;

    // Empty queue with a valid fetch: present it at the outputs right away.
    assign bypass_s      = empty_s && fetch_valid && !flush;
    // ID consumes the forwarded entry in the same cycle, so it is not stored.
    assign bypass_take_s = bypass_s && id_ready;
    assign push_s        = fetch_valid && !full_s && !flush && !bypass_take_s;
`else
    assign push_s        = fetch_valid && !full_s && !flush;
`endif

    // Pop only real stored entries; id_ready is ignored when empty.
    assign pop_s = !empty_s && id_ready && !flush;

    // Next-state for pointers and occupancy; flush overrides push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {(AW + 1){1'b0}};
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + {{(AW - 1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + {{(AW - 1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
                2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write on an accepted push.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_pc_q[wr_ptr_q]    <= pc_in;
            mem_instr_q[wr_ptr_q] <= instr_in;
        end
    end

    // Head outputs: stored head when occupied, otherwise zero (or the bypass).
    always_comb begin
        pc_out    = 16'h0000;
        instr_out = 16'h0000;
        out_valid = 1'b0;
        if (!empty_s) begin
            pc_out    = mem_pc_q[rd_ptr_q];
            instr_out = mem_instr_q[rd_ptr_q];
            out_valid = 1'b1;
        end else begin
`ifdef FETCH_QUEUE_BYPASS_EN
            if (bypass_s) begin
                pc_out    = pc_in;
                instr_out = instr_in;
                out_valid = 1'b1;
            end else begin
                pc_out    = 16'h0000;
                instr_out = 16'h0000;
                out_valid = 1'b0;
            end
`else
            pc_out    = 16'h0000;
            instr_out = 16'h0000;
            out_valid = 1'b0;
`endif
        end
    end

    // Status derives from registered count only, so pc_write has no
    // combinational dependence on fetch_valid or id_ready.
    assign full     = full_s;
    assign empty    = empty_s;
    assign count    = count_q;
    assign pc_write = ~full_s;

endmodule
